// File: rtl/bsg_mesh_router_wormhole_output_arb.sv
// Per-output wormhole arbiter: round-robin grant among head-flit requests,
// then the grant is held for the packet body so flits are never interleaved.
module bsg_mesh_router_wormhole_output_arb #(
    parameter int inputs_p    = 5,
    parameter int len_width_p = 4
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic [inputs_p-1:0]               req_i,
    input  logic [inputs_p-1:0]               v_i,
    input  logic [inputs_p*len_width_p-1:0]   len_i,
    input  logic                              ready_i,
    output logic                              v_o,
    output logic [inputs_p-1:0]               sel_one_hot_o,
    output logic [inputs_p-1:0]               yumi_o,
    output logic                              locked_o
);

    localparam int lg_lp = (inputs_p > 1) ? $clog2(inputs_p) : 1;
    localparam logic [lg_lp-1:0] last_init_lp = lg_lp'(inputs_p - 1);

    typedef enum logic {
        e_idle,
        e_locked
    } state_e;

    state_e                 r_state;
    logic [inputs_p-1:0]    r_owner;
    logic [lg_lp-1:0]       r_last;
    logic [len_width_p-1:0] r_count;

    logic [lg_lp-1:0]       w_grant_idx;
    logic [inputs_p-1:0]    w_grant_oh;
    logic [len_width_p-1:0] w_grant_len;
    logic                   w_found;
    logic [inputs_p-1:0]    w_sel;
    logic                   w_v;
    logic                   w_xfer;

    // Search starts just past the last winner, so it has lowest priority next.
    always_comb begin
        int v_idx;
        w_grant_idx = '0;
        w_grant_oh  = '0;
        w_grant_len = '0;
        w_found     = 1'b0;
        v_idx       = 0;
        for (int k = 1; k <= inputs_p; k++) begin
            v_idx = int'(r_last) + k;
            if (v_idx >= inputs_p) begin
                v_idx = v_idx - inputs_p;
            end
            if (!w_found && req_i[v_idx]) begin
                w_found            = 1'b1;
                w_grant_idx        = v_idx[lg_lp-1:0];
                w_grant_oh[v_idx]  = 1'b1;
                w_grant_len        = len_i[v_idx*len_width_p +: len_width_p];
            end
        end
    end

    always_comb begin
        w_sel = '0;
        w_v   = 1'b0;
        if (!reset_i) begin
            if (r_state == e_locked) begin
                w_sel = r_owner;
                w_v   = |(v_i & r_owner);
            end else begin
                w_sel = w_grant_oh;
                w_v   = w_found;
            end
        end
    end

    assign w_xfer        = w_v & ready_i;
    assign v_o           = w_v;
    assign sel_one_hot_o = w_sel;
    assign yumi_o        = w_sel & {inputs_p{w_xfer}};
    assign locked_o      = (r_state == e_locked) & ~reset_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= e_idle;
            r_owner <= '0;
            r_count <= '0;
            r_last  <= last_init_lp;
        end else begin
            case (r_state)
                e_idle: begin
                    if (w_xfer) begin
                        r_last <= w_grant_idx;
                        // Zero-length packets are head-only and never lock.
                        if (w_grant_len != '0) begin
                            r_owner <= w_grant_oh;
                            r_count <= w_grant_len;
                            r_state <= e_locked;
                        end
                    end
                end
                e_locked: begin
                    if (w_xfer) begin
                        r_count <= r_count - 1'b1;
                        if (r_count == len_width_p'(1)) begin
                            r_state <= e_idle;
                            r_owner <= '0;
                        end
                    end
                end
                default: begin
                    r_state <= e_idle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bsg_mesh_router_wormhole_output_arb.sv
// Directed bench for the wormhole output arbiter (5 inputs, 4-bit length).
module tb_bsg_mesh_router_wormhole_output_arb;

    logic        clk;
    logic        reset_i;
    logic [4:0]  req_i;
    logic [4:0]  v_i;
    logic [19:0] len_i;
    logic        ready_i;
    logic        v_o;
    logic [4:0]  sel_one_hot_o;
    logic [4:0]  yumi_o;
    logic        locked_o;

    int n_total = 0;
    int n_fail  = 0;

    bsg_mesh_router_wormhole_output_arb #(
        .inputs_p   (5),
        .len_width_p(4)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .req_i        (req_i),
        .v_i          (v_i),
        .len_i        (len_i),
        .ready_i      (ready_i),
        .v_o          (v_o),
        .sel_one_hot_o(sel_one_hot_o),
        .yumi_o       (yumi_o),
        .locked_o     (locked_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_len(input int i, input logic [3:0] val);
        len_i[i*4 +: 4] = val;
    endtask

    // Inputs are already applied; settle, check this cycle, then advance.
    task automatic cyc(input string tag, input logic [4:0] ey, input logic [4:0] es,
                       input logic ev, input logic el);
        #1;
        chk({tag, ".yumi"},   32'(yumi_o),        32'(ey));
        chk({tag, ".sel"},    32'(sel_one_hot_o), 32'(es));
        chk({tag, ".v"},      32'(v_o),           32'(ev));
        chk({tag, ".locked"}, 32'(locked_o),      32'(el));
        $display("cycle %s: yumi=%b sel=%b v=%b locked=%b", tag, yumi_o, sel_one_hot_o, v_o, locked_o);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_i = 1'b1;
        req_i   = 5'b11111;
        v_i     = 5'b11111;
        len_i   = '0;
        ready_i = 1'b1;
        @(posedge clk);
        #1;
        cyc("reset", 5'b0, 5'b0, 1'b0, 1'b0);
        reset_i = 1'b0;

        // Round robin, all single-flit packets
        for (int k = 0; k < 10; k++) begin
            cyc($sformatf("rr%0d", k), 5'(1 << (k % 5)), 5'(1 << (k % 5)), 1'b1, 1'b0);
        end

        // Wormhole lock: input 1 len 3, input 3 waits; len change mid-packet ignored
        req_i = 5'b01010; v_i = 5'b01010;
        set_len(1, 4'd3); set_len(3, 4'd0);
        cyc("wh_head", 5'b00010, 5'b00010, 1'b1, 1'b0);
        set_len(1, 4'd9);
        for (int k = 0; k < 3; k++) begin
            cyc($sformatf("wh_body%0d", k), 5'b00010, 5'b00010, 1'b1, 1'b1);
        end
        cyc("wh_next", 5'b01000, 5'b01000, 1'b1, 1'b0);
        req_i = '0; v_i = '0;

        // Backpressure on a len-2 packet from input 2
        req_i = 5'b00100; v_i = 5'b00100; set_len(2, 4'd2);
        ready_i = 1'b1; cyc("bp_head",  5'b00100, 5'b00100, 1'b1, 1'b0);
        req_i = '0;
        ready_i = 1'b0; cyc("bp_stall0", 5'b00000, 5'b00100, 1'b1, 1'b1);
        ready_i = 1'b1; cyc("bp_body",   5'b00100, 5'b00100, 1'b1, 1'b1);
        ready_i = 1'b0; cyc("bp_stall1", 5'b00000, 5'b00100, 1'b1, 1'b1);
        ready_i = 1'b1; cyc("bp_tail",   5'b00100, 5'b00100, 1'b1, 1'b1);
        v_i = '0;
        cyc("bp_idle", 5'b00000, 5'b00000, 1'b0, 1'b0);

        // Bubble: owner 4 goes empty mid-packet while input 0 requests
        req_i = 5'b10001; v_i = 5'b10001; set_len(4, 4'd3); set_len(0, 4'd0);
        cyc("bub_head", 5'b10000, 5'b10000, 1'b1, 1'b0);
        req_i = 5'b00001;
        cyc("bub_body0", 5'b10000, 5'b10000, 1'b1, 1'b1);
        v_i = 5'b00001;
        for (int k = 0; k < 3; k++) begin
            cyc($sformatf("bub_empty%0d", k), 5'b00000, 5'b10000, 1'b0, 1'b1);
        end
        v_i = 5'b10001;
        cyc("bub_body1", 5'b10000, 5'b10000, 1'b1, 1'b1);
        cyc("bub_tail",  5'b10000, 5'b10000, 1'b1, 1'b1);
        cyc("bub_next",  5'b00001, 5'b00001, 1'b1, 1'b0);
        req_i = '0; v_i = '0;

        // Wrap and max length: make 4 the last winner, then 0 vs 4 with len 15
        req_i = 5'b10000; v_i = 5'b10000; set_len(4, 4'd0);
        cyc("wrap_prep", 5'b10000, 5'b10000, 1'b1, 1'b0);
        req_i = 5'b10001; v_i = 5'b10001; set_len(0, 4'd15);
        cyc("wrap_head", 5'b00001, 5'b00001, 1'b1, 1'b0);
        for (int k = 0; k < 15; k++) begin
            cyc($sformatf("wrap_body%0d", k), 5'b00001, 5'b00001, 1'b1, 1'b1);
        end
        cyc("wrap_next", 5'b10000, 5'b10000, 1'b1, 1'b0);
        req_i = '0; v_i = '0;

        // Reset mid-packet: input 2 len 5, two flits, then reset
        req_i = 5'b00100; v_i = 5'b00100; set_len(2, 4'd5);
        cyc("rm_head", 5'b00100, 5'b00100, 1'b1, 1'b0);
        req_i = '0;
        cyc("rm_body", 5'b00100, 5'b00100, 1'b1, 1'b1);
        reset_i = 1'b1;
        cyc("rm_reset", 5'b00000, 5'b00000, 1'b0, 1'b0);
        reset_i = 1'b0;
        req_i = 5'b00101; v_i = 5'b00101; set_len(0, 4'd0);
        cyc("rm_after", 5'b00001, 5'b00001, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end

endmodule
